// File: rtl/ej32_mem_arb.sv
// eJ32 byte RAM port owner: boots the eForth ROM image into RAM,
// then arbitrates the port between the CPU and a debug/host port.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   rom_a / rom_d               boot ROM address out, data in
//   ram_a/ram_we/ram_vi/ram_vo  byte RAM port
//   cpu_req/a/we/vi/vo, hold    CPU load/store path and stall
//   dbg_req/a/we/vi/gnt/vld/vo  debug/host access port
//   boot_done                   image copy finished (sticky)
module ej32_mem_arb #(
  parameter int ASZ        = 16,
  parameter int ROM_SZ     = 8192,
  parameter int ROM_WAIT   = 3,
  parameter int STARVE_MAX = 15
) (
  input  logic           clk,
  input  logic           rst,
  output logic [ASZ-1:0] rom_a,
  input  logic [7:0]     rom_d,
  output logic [ASZ-1:0] ram_a,
  output logic           ram_we,
  output logic [7:0]     ram_vi,
  input  logic [7:0]     ram_vo,
  input  logic           cpu_req,
  input  logic [ASZ-1:0] cpu_a,
  input  logic           cpu_we,
  input  logic [7:0]     cpu_vi,
  output logic [7:0]     cpu_vo,
  output logic           cpu_hold,
  input  logic           dbg_req,
  input  logic [ASZ-1:0] dbg_a,
  input  logic           dbg_we,
  input  logic [7:0]     dbg_vi,
  output logic           dbg_gnt,
  output logic           dbg_vld,
  output logic [7:0]     dbg_vo,
  output logic           boot_done
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    DBG  = 2'd2
  } st_t;

  localparam int WW = (ROM_WAIT > 0) ?
    $clog2(ROM_WAIT + 1) : 1;
  localparam int SW = (STARVE_MAX > 0) ?
    $clog2(STARVE_MAX + 1) : 1;

  localparam logic [ASZ-1:0] LAST  = ASZ'(ROM_SZ - 1);
  localparam logic [WW-1:0]  WLAST = WW'(ROM_WAIT);
  localparam logic [SW-1:0]  SLAST = SW'(STARVE_MAX);

  st_t            state, nstate;
  logic [ASZ-1:0] baddr, nbaddr;
  logic [WW-1:0]  wcnt, nwcnt;
  logic [SW-1:0]  scnt, nscnt;
  logic           vld_q;
  logic [7:0]     vo_q;
  logic           copy;
  logic           dgrant;

  // Last wait cycle of a byte: rom_d is valid now.
  assign copy   = (wcnt == WLAST);
  assign dgrant = dbg_req & ~cpu_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      baddr <= '0;
      wcnt  <= '0;
      scnt  <= '0;
      vld_q <= 1'b0;
      vo_q  <= '0;
    end else begin
      state <= nstate;
      baddr <= nbaddr;
      wcnt  <= nwcnt;
      scnt  <= nscnt;
      vld_q <= dbg_gnt & ~dbg_we;
      if (vld_q)
        vo_q <= ram_vo;
    end
  end

  always_comb begin
    nstate = state;
    nbaddr = baddr;
    nwcnt  = wcnt;
    nscnt  = scnt;
    unique case (state)
      BOOT: begin
        if (copy) begin
          nwcnt  = '0;
          nbaddr = baddr + 1'b1;
          if (baddr == LAST)
            nstate = RUN;
        end else begin
          nwcnt = wcnt + 1'b1;
        end
      end
      RUN: begin
        if (dbg_req && cpu_req) begin
          nscnt = scnt + 1'b1;
          if (scnt + 1'b1 == SLAST)
            nstate = DBG;
        end else begin
          nscnt = '0;
        end
      end
      DBG: begin
        nstate = RUN;
        nscnt  = '0;
      end
      default: nstate = RUN;
    endcase
  end

  always_comb begin
    ram_a    = '0;
    ram_we   = 1'b0;
    ram_vi   = '0;
    cpu_hold = 1'b1;
    dbg_gnt  = 1'b0;
    unique case (state)
      BOOT: begin
        ram_a = baddr;
        // With zero ROM latency every boot cycle writes;
        // keep the strobe quiet while reset is held.
        if (copy && !rst) begin
          ram_we = 1'b1;
          ram_vi = rom_d;
        end
      end
      RUN: begin
        cpu_hold = 1'b0;
        if (dgrant) begin
          ram_a   = dbg_a;
          ram_we  = dbg_we;
          ram_vi  = dbg_vi;
          dbg_gnt = 1'b1;
        end else begin
          ram_a  = cpu_a;
          ram_vi = cpu_vi;
          ram_we = cpu_req & cpu_we;
        end
      end
      DBG: begin
        ram_a   = dbg_a;
        ram_we  = dbg_we;
        ram_vi  = dbg_vi;
        dbg_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  assign rom_a     = baddr;
  assign cpu_vo    = ram_vo;
  assign boot_done = (state != BOOT);
  assign dbg_vld   = vld_q;
  // RAM data lands one cycle after the grant; hold it afterwards.
  assign dbg_vo    = vld_q ? ram_vo : vo_q;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb: boot copy (ROM_WAIT 3 and 0),
// debug/CPU arbitration vectors, starvation, mid-boot reset.
module tb_ej32_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] rom_a, ram_a, cpu_a, dbg_a;
  logic [7:0]  rom_d, ram_vi, ram_vo, cpu_vi, cpu_vo;
  logic [7:0]  dbg_vi, dbg_vo;
  logic        ram_we, cpu_req, cpu_we, cpu_hold;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_vld, boot_done;

  logic [15:0] rom_a0, ram_a0;
  logic [7:0]  rom_d0, ram_vi0, cpu_vo0, dbg_vo0;
  logic        ram_we0, cpu_hold0, dbg_gnt0, dbg_vld0;
  logic        boot_done0;
  logic        z1 = 1'b0;
  logic [15:0] z16 = '0;
  logic [7:0]  z8 = '0;

  ej32_mem_arb #(
    .ASZ(16), .ROM_SZ(16), .ROM_WAIT(3), .STARVE_MAX(15)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_a(rom_a), .rom_d(rom_d),
    .ram_a(ram_a), .ram_we(ram_we),
    .ram_vi(ram_vi), .ram_vo(ram_vo),
    .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_we(cpu_we),
    .cpu_vi(cpu_vi), .cpu_vo(cpu_vo), .cpu_hold(cpu_hold),
    .dbg_req(dbg_req), .dbg_a(dbg_a), .dbg_we(dbg_we),
    .dbg_vi(dbg_vi), .dbg_gnt(dbg_gnt), .dbg_vld(dbg_vld),
    .dbg_vo(dbg_vo), .boot_done(boot_done)
  );

  ej32_mem_arb #(
    .ASZ(16), .ROM_SZ(16), .ROM_WAIT(0), .STARVE_MAX(15)
  ) u0 (
    .clk(clk), .rst(rst),
    .rom_a(rom_a0), .rom_d(rom_d0),
    .ram_a(ram_a0), .ram_we(ram_we0),
    .ram_vi(ram_vi0), .ram_vo(z8),
    .cpu_req(z1), .cpu_a(z16), .cpu_we(z1),
    .cpu_vi(z8), .cpu_vo(cpu_vo0), .cpu_hold(cpu_hold0),
    .dbg_req(z1), .dbg_a(z16), .dbg_we(z1),
    .dbg_vi(z8), .dbg_gnt(dbg_gnt0), .dbg_vld(dbg_vld0),
    .dbg_vo(dbg_vo0), .boot_done(boot_done0)
  );

  // ROM with 3-cycle latency: data follows rom_a three edges late.
  logic [15:0] d1 = '0, d2 = '0, d3 = '0;
  always @(posedge clk) begin
    d1 <= rom_a;
    d2 <= d1;
    d3 <= d2;
  end
  assign rom_d  = d3[7:0] ^ d3[15:8] ^ 8'hA5;
  assign rom_d0 = rom_a0[7:0] ^ rom_a0[15:8] ^ 8'hA5;

  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we)
      mem[ram_a] <= ram_vi;
    ram_vo <= mem[ram_a];
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Call right after reset release; ends at the negedge of cycle 64.
  task automatic boot_run(input bit dbg_pend);
    @(negedge clk);
    for (int n = 0; n <= 64; n++) begin
      if (n < 64) begin
        chk("boot_we", 32'(ram_we), 32'(n % 4 == 3));
        if (n % 4 == 3) begin
          chk("boot_a", 32'(ram_a), 32'(n / 4));
          chk("boot_vi", 32'(ram_vi), 32'((n / 4) ^ 'hA5));
        end
        chk("boot_hold", 32'(cpu_hold), 32'd1);
        chk("boot_done_lo", 32'(boot_done), 32'd0);
        chk("boot_gnt", 32'(dbg_gnt), 32'd0);
      end else begin
        chk("boot_done_hi", 32'(boot_done), 32'd1);
        chk("run_hold", 32'(cpu_hold), 32'd0);
        chk("run_gnt", 32'(dbg_gnt), 32'(dbg_pend));
        if (dbg_pend) begin
          chk("run_gnt_a", 32'(ram_a), 32'h50);
          chk("run_gnt_we", 32'(ram_we), 32'd0);
        end
      end
      chk("w0_we", 32'(ram_we0), 32'(n < 16));
      if (n < 16) begin
        chk("w0_a", 32'(ram_a0), 32'(n));
        chk("w0_vi", 32'(ram_vi0), 32'(n ^ 'hA5));
      end
      chk("w0_done", 32'(boot_done0), 32'(n >= 16));
      chk("w0_hold", 32'(cpu_hold0), 32'(n < 16));
      chk("w0_dbg", 32'({dbg_gnt0, dbg_vld0}), 32'd0);
      if (n < 64)
        @(negedge clk);
    end
  endtask

  typedef struct {
    logic        creq;
    logic [15:0] ca;
    logic        cwe;
    logic [7:0]  cvi;
    logic        dreq;
    logic [15:0] da;
    logic        dwe;
    logic [7:0]  dvi;
    logic [15:0] ea;
    logic        ewe;
    logic [7:0]  evi;
    logic        egnt;
    logic        evld;
    logic [7:0]  evo;
    logic        ccvo;
    logic [7:0]  ecvo;
  } vec_t;

  vec_t tv [10];

  initial begin
    tv[0] = '{1, 'h200, 1, 'h77, 0, 0, 0, 0,
              'h200, 1, 'h77, 0, 0, 0, 0, 0};
    tv[1] = '{1, 'h200, 0, 'h11, 0, 0, 0, 0,
              'h200, 0, 'h11, 0, 0, 0, 0, 0};
    tv[2] = '{0, 'h300, 1, 'h22, 0, 0, 0, 0,
              'h300, 0, 'h22, 0, 0, 0, 1, 'h77};
    tv[3] = '{0, 'h300, 0, 0, 1, 'h400, 1, 'h5A,
              'h400, 1, 'h5A, 1, 0, 0, 0, 0};
    tv[4] = '{1, 'h204, 1, 'h01, 1, 'h200, 0, 'h99,
              'h204, 1, 'h01, 0, 0, 0, 0, 0};
    tv[5] = '{1, 'h204, 0, 0, 0, 0, 0, 0,
              'h204, 0, 0, 0, 0, 0, 0, 0};
    tv[6] = '{0, 0, 0, 0, 1, 'h200, 0, 0,
              'h200, 0, 0, 1, 0, 0, 1, 'h01};
    tv[7] = '{0, 0, 0, 0, 1, 'h400, 0, 0,
              'h400, 0, 0, 1, 1, 'h77, 0, 0};
    tv[8] = '{0, 0, 0, 0, 0, 0, 0, 0,
              0, 0, 0, 0, 1, 'h5A, 0, 0};
    tv[9] = '{0, 0, 0, 0, 0, 0, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0};

    mem[16'h0050] = 8'h12;
    cpu_req = 0; cpu_a = 0; cpu_we = 0; cpu_vi = 0;
    dbg_req = 0; dbg_a = 0; dbg_we = 0; dbg_vi = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_a", 32'(rom_a), 0);
    chk("rst_ram_a", 32'(ram_a), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_vi", 32'(ram_vi), 0);
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_gnt", 32'(dbg_gnt), 0);
    chk("rst_vld", 32'(dbg_vld), 0);
    chk("rst_vo", 32'(dbg_vo), 0);
    chk("rst_done", 32'(boot_done), 0);
    chk("rst_w0_we", 32'(ram_we0), 0);
    chk("rst_w0_vo", 32'({cpu_vo0, dbg_vo0}), 0);

    // Debug read pending throughout boot.
    dbg_req = 1; dbg_a = 16'h0050; dbg_we = 0;
    @(posedge clk); #1 rst = 0;
    boot_run(1);
    @(posedge clk); #1 dbg_req = 0;
    @(negedge clk);
    chk("dbg_vld", 32'(dbg_vld), 1);
    chk("dbg_vo", 32'(dbg_vo), 32'h12);
    chk("dbg_hold", 32'(cpu_hold), 0);
    @(negedge clk);
    chk("dbg_vld_end", 32'(dbg_vld), 0);
    chk("dbg_vo_hold", 32'(dbg_vo), 32'h12);
    for (int k = 0; k < 16; k++)
      chk("boot_mem", 32'(mem[k]), 32'(k ^ 'hA5));

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cpu_req = tv[i].creq; cpu_a = tv[i].ca;
      cpu_we = tv[i].cwe;   cpu_vi = tv[i].cvi;
      dbg_req = tv[i].dreq; dbg_a = tv[i].da;
      dbg_we = tv[i].dwe;   dbg_vi = tv[i].dvi;
      @(negedge clk);
      chk($sformatf("v%0d_a", i), 32'(ram_a), 32'(tv[i].ea));
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(tv[i].ewe));
      chk($sformatf("v%0d_vi", i), 32'(ram_vi), 32'(tv[i].evi));
      chk($sformatf("v%0d_gnt", i), 32'(dbg_gnt), 32'(tv[i].egnt));
      chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 0);
      chk($sformatf("v%0d_vld", i), 32'(dbg_vld), 32'(tv[i].evld));
      if (tv[i].evld)
        chk($sformatf("v%0d_vo", i), 32'(dbg_vo), 32'(tv[i].evo));
      if (tv[i].ccvo)
        chk($sformatf("v%0d_cvo", i), 32'(cpu_vo), 32'(tv[i].ecvo));
    end

    // Starvation: CPU busy every cycle, debug write waiting.
    @(posedge clk); #1;
    cpu_req = 1; cpu_a = 16'h0210; cpu_we = 0; cpu_vi = 0;
    dbg_req = 1; dbg_a = 16'h0100; dbg_we = 1; dbg_vi = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 15) begin
        chk("stv_hold", 32'(cpu_hold), 0);
        chk("stv_gnt", 32'(dbg_gnt), 0);
        chk("stv_a", 32'(ram_a), 32'h210);
      end else begin
        chk("stv_dbg_hold", 32'(cpu_hold), 1);
        chk("stv_dbg_we", 32'(ram_we), 1);
        chk("stv_dbg_a", 32'(ram_a), 32'h100);
        chk("stv_dbg_vi", 32'(ram_vi), 32'h3C);
        chk("stv_dbg_gnt", 32'(dbg_gnt), 1);
      end
    end
    @(posedge clk); #1 dbg_req = 0;
    @(negedge clk);
    chk("stv_after_hold", 32'(cpu_hold), 0);
    chk("stv_after_a", 32'(ram_a), 32'h210);
    chk("stv_after_gnt", 32'(dbg_gnt), 0);
    chk("stv_after_vld", 32'(dbg_vld), 0);
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk);
    chk("stv_mem", 32'(mem[16'h0100]), 32'h3C);

    // Fresh boot, then reset in the middle of byte 7.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (29) @(posedge clk);
    #1;
    chk("mid_rom_a", 32'(rom_a), 7);
    #3 rst = 1;
    #1;
    chk("mid_rst_rom_a", 32'(rom_a), 0);
    chk("mid_rst_ram_a", 32'(ram_a), 0);
    chk("mid_rst_we", 32'(ram_we), 0);
    chk("mid_rst_hold", 32'(cpu_hold), 1);
    chk("mid_rst_done", 32'(boot_done), 0);
    @(posedge clk); #1 rst = 0;
    boot_run(0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ej32_mem_arb.md
Name: ej32_mem_arb

Overview:
- Owns the single byte-wide RAM port of the eJ32 core.
- After reset it runs a boot sequencer that copies the eForth ROM image into RAM while holding the CPU stalled.
- It then arbitrates the RAM port between the CPU load/store path and a debug/host port, which is used for post-run RAM dumps and patching.
- It sits between the top-level core and the byte memory interface.

Parameters:
- ASZ, 16: address width in bits.
- ROM_SZ, 8192: number of image bytes copied at boot.
- ROM_WAIT, 3: ROM read latency in cycles (0 means rom_d is valid in the same cycle as rom_a).
- STARVE_MAX, 15: number of consecutive cycles a pending debug request may lose to the CPU before it is forced through.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rom_a  out  ASZ  boot ROM byte address
- rom_d  in  8  ROM data, valid ROM_WAIT cycles after rom_a changes
- ram_a  out  ASZ  RAM byte address
- ram_we  out  1  RAM write strobe
- ram_vi  out  8  RAM write data
- ram_vo  in  8  RAM read data, valid 1 cycle after ram_a
- cpu_req  in  1  CPU access request this cycle
- cpu_a  in  ASZ  CPU address
- cpu_we  in  1  CPU write
- cpu_vi  in  8  CPU write data
- cpu_vo  out  8  CPU read data (ram_vo pass-through)
- cpu_hold  out  1  CPU stall; the CPU keeps req/a/we/vi stable while this is high
- dbg_req  in  1  debug request, held until dbg_gnt
- dbg_a  in  ASZ  debug address
- dbg_we  in  1  debug write
- dbg_vi  in  8  debug write data
- dbg_gnt  out  1  1-cycle pulse: the debug access is on the RAM port this cycle
- dbg_vld  out  1  1-cycle pulse the cycle after a debug read grant
- dbg_vo  out  8  registered debug read data
- boot_done  out  1  high once the image copy has completed

Behaviour:
- Reset (asynchronous, any time, including mid-boot): state=BOOT, boot address=0, wait counter=0, starve counter=0.
- Output reset values: rom_a=0, ram_a=0, ram_we=0, ram_vi=0, cpu_hold=1, dbg_gnt=0, dbg_vld=0, dbg_vo=0, boot_done=0.
- A boot restarts from address 0 after any reset.
- States: BOOT, RUN, DBG.
- BOOT, per byte k from 0 to ROM_SZ-1:
  - rom_a=k for ROM_WAIT+1 cycles.
  - On the last of those cycles: ram_a=k, ram_vi=rom_d, ram_we=1.
  - Then k increments and the wait counter clears.
  - ram_we=0 on all other BOOT cycles.
- BOOT duration: exactly ROM_SZ*(ROM_WAIT+1) cycles. The cycle after the final write: boot_done=1 (sticky until reset), cpu_hold=0, state=RUN.
- BOOT restrictions: cpu_req and dbg_req are ignored. A debug request stays pending and is arbitrated normally once in RUN.
- RUN, port muxing: the CPU owns the port combinationally.
  - ram_a=cpu_a, ram_vi=cpu_vi, ram_we=cpu_req&cpu_we.
  - cpu_vo=ram_vo in all states.
- RUN, debug arbitration, evaluated every cycle:
  - dbg_req=1 and cpu_req=0: the debug access goes on the port in the same cycle. ram_a=dbg_a, ram_we=dbg_we, ram_vi=dbg_vi, dbg_gnt=1. State stays RUN.
  - dbg_req=1 and cpu_req=1: the CPU wins and the starve counter increments.
  - When the counter reaches STARVE_MAX: next cycle state=DBG.
  - dbg_req=0: starve counter clears.
- DBG (exactly 1 cycle):
  - cpu_hold=1.
  - The debug access drives the port; dbg_gnt=1.
  - Starve counter clears; next state=RUN, cpu_hold=0.
  - The held CPU access is serviced in that following RUN cycle, with priority over any new debug request.
- Debug read data: the cycle after any dbg_gnt with dbg_we=0, dbg_vld=1 and dbg_vo=ram_vo. No dbg_vld after a write grant.
- Back-to-back debug reads with the CPU idle: one grant per cycle, and dbg_vld pipelines 1 cycle behind.
- Address arithmetic: boot address counter is ASZ bits. ROM_SZ must be at most 2^ASZ; the counter never wraps during boot.

Test Plan:
- Boot copy, ROM_SZ=16, ROM_WAIT=3, ROM model returns byte (addr^0xA5):
  - 16 ram_we pulses at cycles 3, 7, …, 63 after reset release, each with ram_a=k and ram_vi=k^0xA5.
  - boot_done=1 and cpu_hold=0 at cycle 64.
- ROM_WAIT=0:
  - One write per cycle.
  - boot_done rises at cycle ROM_SZ.
- CPU idle debug read, dbg_a=0x0050, RAM holds 0x12 there:
  - dbg_gnt in the same cycle.
  - Next cycle dbg_vld=1, dbg_vo=0x12.
  - cpu_hold stays 0.
- Starvation: cpu_req held at 1 continuously and a debug write (dbg_a=0x0100, dbg_vi=0x3C) pending:
  - After 15 CPU cycles, cpu_hold=1 for exactly one cycle, with ram_we=1, ram_a=0x0100, ram_vi=0x3C, dbg_gnt=1.
  - The CPU access resumes the next cycle.
  - No dbg_vld.
- dbg_req asserted during BOOT:
  - No grant before boot_done.
  - Granted in the first RUN cycle if cpu_req=0.
- Reset asserted mid-boot at byte 7:
  - Outputs return to their reset values immediately.
  - Copy restarts at address 0.
  - boot_done follows the full ROM_SZ*(ROM_WAIT+1) duration from the reset release.
